mult_arbiter: RTL and testbench
===============================

# mult_arbiter

Shares one add/shift multiplier datapath (start/done handshake, 2N-bit product) between NREQ requesters. Round-robin arbitration selects one request at a time. The block latches that request's operands, starts the multiplier, and waits for its done pulse. It then returns the tagged product over a valid/ready response channel. It sits between the requester logic and the multiplier FSM/datapath and is the only block allowed to drive the multiplier start.

## Interface
- N, 32, operand width; product is 2N bits
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 128, max BUSY cycles before abort (used only with MULT_ARB_TIMEOUT_EN)

- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- REQ  in  NREQ  per-requester request level
- A_IN  in  NREQ*N  packed multiplicands, requester i at [i*N +: N]
- B_IN  in  NREQ*N  packed multipliers, same packing
- GNT  out  NREQ  one-hot acceptance pulse, registered
- MUL_ST  out  1  multiplier start pulse
- MUL_A, MUL_B  out  N  operands to datapath, held from ISSUE through end of BUSY
- MUL_CLR  out  1  datapath clear pulse (timeout abort)
- MUL_DONE  in  1  multiplier done
- MUL_PROD  in  2N  multiplier product, valid when MUL_DONE=1
- RSP_VALID  out  1  response valid
- RSP_ID  out  clog2(NREQ)  index of the served requester
- RSP_PROD  out  2N  product
- RSP_ERR  out  1  response is an aborted operation
- RSP_READY  in  1  consumer accepts response

## Operation
- States: IDLE, ISSUE, BUSY, RESP. All outputs are registered.
- IDLE: REQ sampled only here. If REQ≠0, pick the first set bit searching upward from LAST+1 (mod NREQ). On that edge: latch A/B of the winner into MUL_A/MUL_B, set GNT[winner]=1 and MUL_ST=1, LAST←winner, ID←winner, go to ISSUE.
- ISSUE, one cycle: GNT and MUL_ST high. At the next edge both clear and the state goes to BUSY.
- BUSY: wait for MUL_DONE=1. On that edge: RSP_PROD←MUL_PROD, RSP_ERR←0, RSP_VALID←1, go to RESP.
- RESP: hold RSP_VALID/RSP_ID/RSP_PROD/RSP_ERR stable until RSP_VALID&RSP_READY. On that edge: RSP_VALID←0, go to IDLE.
- Requester rules: hold REQ and operands stable until it sees GNT, then drop REQ the following cycle. A REQ still high in IDLE counts as a new request.
- MUL_DONE outside BUSY is ignored. A MUL_DONE coinciding with the ISSUE cycle is ignored.
- Fairness: LAST resets to NREQ-1, so requester 0 wins first. Under continuous REQ from all requesters, grants rotate 0,1,2,3,0…
- Reset (any state, any time): state←IDLE, LAST←NREQ-1. GNT, MUL_ST, MUL_CLR, RSP_VALID, RSP_ERR and all data outputs reset to 0. An in-flight operation is discarded with no response.

## Timing
- REQ seen in IDLE at edge k: GNT/MUL_ST high during cycle k..k+1, BUSY from edge k+1.
- MUL_DONE high at edge d in BUSY: RSP_VALID high from edge d.
- Minimum request-to-response: 3 edges plus the multiplier latency.
- Zero-wait RESP (RSP_READY already high): back in IDLE one cycle after RSP_VALID rises.
- Minimum spacing between consecutive GNT pulses: multiplier latency + 4 cycles.
- Throughput: one operation in flight; no pipelining.

## Configuration
- MULT_ARB_TIMEOUT_EN defined:
  - A counter clears on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without MUL_DONE, the next edge sets MUL_CLR=1 for one cycle, RSP_PROD←0, RSP_ERR←1, RSP_VALID←1, and goes to RESP.
  - MUL_DONE arriving on the same edge as the timeout wins, giving a normal response.
- MULT_ARB_TIMEOUT_EN undefined:
  - No counter.
  - BUSY waits indefinitely.
  - MUL_CLR and RSP_ERR are tied to 0.

## Test plan
- Single request, timing and product: REQ=4'b0010, A=7, B=6 → GNT=4'b0010 for one cycle, MUL_ST one cycle. Model done after 100 cycles → RSP_ID=1, RSP_PROD=42, RSP_ERR=0.
- Round-robin: REQ=4'b1111 held, RSP_READY=1, products A=i+1, B=3 → grant order 0,1,2,3,0 with RSP_PROD 3,6,9,12,3.
- Backpressure: RSP_READY=0 for 20 cycles after RSP_VALID → outputs stable, no new GNT. RSP_READY=1 → IDLE next cycle, then the next grant.
- Max operands: A=B=32'hFFFFFFFF → RSP_PROD=64'hFFFFFFFE00000001.
- Reset mid-BUSY: RST_N low for 1 cycle → all outputs 0, no response. Next REQ=4'b1000 grants requester 3; with REQ=4'b1001, requester 0 wins.
- With MULT_ARB_TIMEOUT_EN, model never asserts done → MUL_CLR pulse after 128 BUSY cycles, RSP_ERR=1, RSP_PROD=0. Without the macro, no response after 1000 cycles.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end sharing one start/done multiplier; MULT_ARB_TIMEOUT_EN adds a BUSY-timeout abort
module mult_arbiter #(
    parameter  int N       = 32,
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 128,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*N-1:0] A_IN,
    input  logic [NREQ*N-1:0] B_IN,
    output logic [NREQ-1:0]   GNT,
    output logic              MUL_ST,
    output logic [N-1:0]      MUL_A,
    output logic [N-1:0]      MUL_B,
    output logic              MUL_CLR,
    input  logic              MUL_DONE,
    input  logic [2*N-1:0]    MUL_PROD,
    output logic              RSP_VALID,
    output logic [IDW-1:0]    RSP_ID,
    output logic [2*N-1:0]    RSP_PROD,
    output logic              RSP_ERR,
    input  logic              RSP_READY
);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
    state_t state;
    logic [IDW-1:0] last, win, idx;
`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT > 0;
    assign MUL_CLR = 1'b0;
    assign RSP_ERR = 1'b0;
`endif
    // first requester after last, wrapping; scanning farthest-first lets the nearest overwrite
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (REQ[idx]) win = idx;
        end
    end
    // control FSM with registered grant, start and response outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            last      <= IDW'(NREQ - 1);
            GNT       <= '0;
            MUL_ST    <= 1'b0;
            MUL_A     <= '0;
            MUL_B     <= '0;
            RSP_VALID <= 1'b0;
            RSP_ID    <= '0;
            RSP_PROD  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            MUL_CLR   <= 1'b0;
            RSP_ERR   <= 1'b0;
            cnt       <= '0;
`endif
        end else begin
`ifdef MULT_ARB_TIMEOUT_EN
            MUL_CLR <= 1'b0;
`endif
            case (state)
                IDLE: if (|REQ) begin
                    MUL_A       <= A_IN[int'(win)*N +: N];
                    MUL_B       <= B_IN[int'(win)*N +: N];
                    GNT[win]    <= 1'b1;
                    MUL_ST      <= 1'b1;
                    last        <= win;
                    RSP_ID      <= win;
                    state       <= ISSUE;
                end
                ISSUE: begin
                    GNT    <= '0;
                    MUL_ST <= 1'b0;
                    state  <= BUSY;
`ifdef MULT_ARB_TIMEOUT_EN
                    cnt    <= '0;
`endif
                end
                BUSY: if (MUL_DONE) begin
                    RSP_PROD  <= MUL_PROD;
                    RSP_VALID <= 1'b1;
                    state     <= RESP;
`ifdef MULT_ARB_TIMEOUT_EN
                    RSP_ERR   <= 1'b0;
                end else if (cnt == CW'(TIMEOUT)) begin
                    MUL_CLR   <= 1'b1;
                    RSP_PROD  <= '0;
                    RSP_ERR   <= 1'b1;
                    RSP_VALID <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
`endif
                end
                RESP: if (RSP_READY) begin
                    RSP_VALID <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed checks of arbitration, timing, backpressure, reset and timeout
module tb_mult_arbiter;
    logic         CLK, RST_N;
    logic [3:0]   REQ;
    logic [127:0] A_IN, B_IN;
    logic [3:0]   GNT;
    logic         MUL_ST, MUL_CLR, MUL_DONE;
    logic [31:0]  MUL_A, MUL_B;
    logic [63:0]  MUL_PROD, RSP_PROD;
    logic         RSP_VALID, RSP_ERR, RSP_READY;
    logic [1:0]   RSP_ID;
    int n_tests = 0, n_fail = 0, cyc = 0, lat = 2;
    bit never = 0;

    mult_arbiter #(.N(32), .NREQ(4), .TIMEOUT(128)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
        .GNT(GNT), .MUL_ST(MUL_ST), .MUL_A(MUL_A), .MUL_B(MUL_B), .MUL_CLR(MUL_CLR),
        .MUL_DONE(MUL_DONE), .MUL_PROD(MUL_PROD), .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID),
        .RSP_PROD(RSP_PROD), .RSP_ERR(RSP_ERR), .RSP_READY(RSP_READY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // multiplier model: done pulse lat edges after the start is seen
    initial begin
        MUL_DONE = 1'b0;
        MUL_PROD = '0;
        forever begin
            @(posedge CLK);
            if (MUL_ST === 1'b1 && !never) begin
                repeat (lat) @(posedge CLK);
                #1 MUL_DONE = 1'b1;
                MUL_PROD = 64'(MUL_A) * 64'(MUL_B);
                @(posedge CLK);
                #1 MUL_DONE = 1'b0;
                MUL_PROD = '0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1 cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input string tag, input int lim);
        int n = 0;
        while (GNT === 4'b0 && n < lim) begin
            tick();
            n++;
        end
        chk({tag, "_gnt_wait"}, n < lim, 1);
    endtask

    task automatic wait_rsp(input string tag, input int lim, output int n);
        n = 0;
        while (RSP_VALID !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_wait"}, n < lim, 1);
    endtask

    initial begin
        int n, g_prev;
        logic [3:0] eg;
        bit bad;
        RST_N = 1'b0; REQ = '0; A_IN = '0; B_IN = '0; RSP_READY = 1'b1;
        tick(); tick();
        chk("rst_gnt", GNT, 0);
        chk("rst_st", MUL_ST, 0);
        chk("rst_valid", RSP_VALID, 0);
        chk("rst_clr", MUL_CLR, 0);
        chk("rst_err", RSP_ERR, 0);
        chk("rst_mula", MUL_A, 0);
        chk("rst_prod", RSP_PROD, 0);
        RST_N = 1'b1;
        tick();

        // round robin under continuous requests
        for (int i = 0; i < 4; i++) begin
            A_IN[i*32 +: 32] = 32'(i + 1);
            B_IN[i*32 +: 32] = 32'd3;
        end
        lat = 2;
        REQ = 4'b1111;
        g_prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_gnt("rr", 50);
            eg = 4'b1 << (i % 4);
            chk("rr_gnt", GNT, eg);
            chk("rr_st", MUL_ST, 1);
            if (i > 0) chk("rr_spacing", cyc - g_prev, 6);
            g_prev = cyc;
            wait_rsp("rr", 50, n);
            chk("rr_id", RSP_ID, i % 4);
            chk("rr_prod", RSP_PROD, 64'(((i % 4) + 1) * 3));
        end
        REQ = '0;
        tick();

        // single request, 100-cycle multiplier, then backpressure
        lat = 100;
        RSP_READY = 1'b0;
        A_IN[32 +: 32] = 32'd7;
        B_IN[32 +: 32] = 32'd6;
        REQ = 4'b0010;
        tick();
        chk("one_gnt", GNT, 4'b0010);
        chk("one_st", MUL_ST, 1);
        chk("one_mula", MUL_A, 7);
        chk("one_mulb", MUL_B, 6);
        REQ = '0;
        tick();
        chk("one_gnt_clr", GNT, 0);
        chk("one_st_clr", MUL_ST, 0);
        wait_rsp("one", 200, n);
        chk("one_latency", n, 101);
        chk("one_id", RSP_ID, 1);
        chk("one_prod", RSP_PROD, 42);
        chk("one_err", RSP_ERR, 0);
        A_IN[31:0] = 32'hFFFFFFFF;
        B_IN[31:0] = 32'hFFFFFFFF;
        REQ = 4'b0001;
        lat = 3;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_valid", RSP_VALID, 1);
            chk("bp_prod", RSP_PROD, 42);
            chk("bp_gnt", GNT, 0);
        end
        RSP_READY = 1'b1;
        tick();
        chk("bp_release_valid", RSP_VALID, 0);
        chk("bp_release_gnt", GNT, 0);
        tick();
        chk("bp_next_gnt", GNT, 4'b0001);
        REQ = '0;
        wait_rsp("max", 50, n);
        chk("max_id", RSP_ID, 0);
        chk("max_prod", RSP_PROD, 64'hFFFFFFFE00000001);
        tick();

        // reset in the middle of BUSY
        lat = 20;
        A_IN[64 +: 32] = 32'd9;
        B_IN[64 +: 32] = 32'd9;
        REQ = 4'b0100;
        wait_gnt("mid", 10);
        chk("mid_gnt", GNT, 4'b0100);
        REQ = '0;
        tick(); tick(); tick();
        RST_N = 1'b0;
        tick();
        chk("mid_rst_gnt", GNT, 0);
        chk("mid_rst_st", MUL_ST, 0);
        chk("mid_rst_valid", RSP_VALID, 0);
        chk("mid_rst_mula", MUL_A, 0);
        chk("mid_rst_mulb", MUL_B, 0);
        chk("mid_rst_id", RSP_ID, 0);
        chk("mid_rst_prod", RSP_PROD, 0);
        RST_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (RSP_VALID !== 1'b0 || GNT !== 4'b0) bad = 1;
        end
        chk("mid_no_rsp", bad, 0);
        lat = 2;
        A_IN[96 +: 32] = 32'd10;
        B_IN[96 +: 32] = 32'd10;
        REQ = 4'b1000;
        wait_gnt("post3", 10);
        chk("post3_gnt", GNT, 4'b1000);
        REQ = '0;
        wait_rsp("post3", 50, n);
        chk("post3_id", RSP_ID, 3);
        chk("post3_prod", RSP_PROD, 100);
        A_IN[31:0] = 32'd2;
        B_IN[31:0] = 32'd21;
        REQ = 4'b1001;
        wait_gnt("post0", 10);
        chk("post0_gnt", GNT, 4'b0001);
        REQ = '0;
        wait_rsp("post0", 50, n);
        chk("post0_id", RSP_ID, 0);
        chk("post0_prod", RSP_PROD, 42);
        tick();

        // multiplier that never finishes
        never = 1;
        REQ = 4'b0010;
        wait_gnt("to", 10);
        chk("to_gnt", GNT, 4'b0010);
        REQ = '0;
`ifdef MULT_ARB_TIMEOUT_EN
        n = 0;
        while (MUL_CLR !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("to_clr_cycles", n, 130);
        chk("to_valid", RSP_VALID, 1);
        chk("to_err", RSP_ERR, 1);
        chk("to_prod", RSP_PROD, 0);
        chk("to_id", RSP_ID, 1);
        tick();
        chk("to_clr_pulse", MUL_CLR, 0);
        chk("to_valid_drop", RSP_VALID, 0);
`else
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (RSP_VALID !== 1'b0 || MUL_CLR !== 1'b0 || RSP_ERR !== 1'b0) bad = 1;
        end
        chk("to_no_rsp", bad, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
